axi_lite_slave_if: RTL and testbench
====================================

Name: axi_lite_slave_if

Overview:
- AXI4-Lite slave front end for the PL control plane; terminates the PS GP-port AXI4-Lite bus.
- Converts the five AXI channels into the flat request/done interface consumed by the address decode stage: waddr/wdata/we with wdone, and raddr/re with rdone/rdata.
- Independent write and read FSMs hold each request until the downstream done arrives or a timeout expires, then return B/R responses.

Parameters:
- ADDR_W, 32, AXI address width; also the waddr/raddr width.
- DATA_W, 32, data width. Only 32 is supported.
- TIMEOUT_CYCLES, 256, maximum cycles to wait for wdone/rdone before returning SLVERR. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- s_axi_awaddr  in  ADDR_W  write address
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- s_axi_wdata  in  DATA_W  write data
- s_axi_wstrb  in  DATA_W/8  write strobes
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  B valid
- s_axi_bready  in  1  B ready
- s_axi_araddr  in  ADDR_W  read address
- s_axi_arvalid  in  1  AR valid
- s_axi_arready  out  1  AR ready
- s_axi_rdata  out  DATA_W  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  R valid
- s_axi_rready  in  1  R ready
- waddr  out  ADDR_W  registered write address to decode
- wdata  out  DATA_W  registered write data to decode
- we  out  1  write request, level, held until done
- wdone  in  1  write complete from decode
- raddr  out  ADDR_W  registered read address to decode
- re  out  1  read request, level, held until done
- rdone  in  1  read complete from decode
- rdata  in  DATA_W  read data from decode, valid with rdone

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. All outputs are 0 in reset, including awready, wready, arready, bvalid, rvalid, we, re, bresp, rresp, rdata, waddr, wdata and raddr. Both FSMs go to IDLE and the timeout counters clear.
- Reset mid-transaction aborts the transaction with no response. The master is reset together with this block.

Write FSM, states W_IDLE, W_REQ, W_RESP:
- W_IDLE: awready = !aw_captured and wready = !w_captured. AW and W may complete in the same cycle or in either order; each is latched on its handshake.
- Once both are captured (earliest cycle N, when both handshake in N), the FSM enters W_REQ in N+1.
- If wstrb != all-ones, the FSM skips W_REQ, goes straight to W_RESP with SLVERR, and we is never asserted.
- W_REQ: we=1, with waddr/wdata stable. The counter increments every cycle.
  - wdone=1 sampled: we=0 next cycle, bresp=OKAY, go to W_RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without wdone: we=0, bresp=SLVERR(2'b10), go to W_RESP.
- W_RESP: bvalid=1 and bresp held until bready; then go to W_IDLE with the captured flags cleared.
- awready and wready are 0 outside W_IDLE.
- Best-case latency: handshake N, we in N+1, wdone in N+1, bvalid in N+2.

Read FSM, states R_IDLE, R_REQ, R_RESP:
- R_IDLE: arready=1. On the AR handshake, latch raddr and go to R_REQ.
- R_REQ: re=1.
  - rdone=1: latch rdata into s_axi_rdata, rresp=OKAY, re=0, go to R_RESP.
  - Timeout: rdata=0, rresp=SLVERR.
- R_RESP: rvalid=1 until rready, then go to R_IDLE.
- Best-case latency: AR handshake N, rvalid in N+2.

Other rules:
- The write and read paths are fully independent; simultaneous we and re are legal.
- wdone asserted outside W_REQ (and rdone outside R_REQ) is ignored.
- A done arriving in the same cycle as the timeout expiry takes priority and returns OKAY.
- Only one outstanding transaction per direction. Address bits [1:0] pass through unmodified.

Decomposition:
- Package axi_lite_pkg holds:
  - the response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the enums wr_state_t and rd_state_t.
- The timeout counter is instantiated twice as sub-module req_timeout, with inputs clk, rst, start, active and done and output expired, parameterised by TIMEOUT_CYCLES.

Test Plan:
- AW and W in the same cycle: awaddr=0x0000_0010, wdata=0xA5A5_5A5A, wstrb=0xF, wdone on the first we cycle -> we high for 1 cycle with waddr=0x10 and wdata=0xA5A5_5A5A; bvalid 2 cycles after the handshake; bresp=00.
- W three cycles before AW, with bready held low for 4 cycles -> we only after AW; bvalid stays high with stable bresp until bready; no new awready until the B handshake.
- Read araddr=0x0000_0004, rdone 3 cycles after re rises with rdata=0x1234_5678 -> rvalid with rdata=0x1234_5678 and rresp=00; re drops the cycle after rdone.
- TIMEOUT_CYCLES=8, wdone held low -> we high for exactly 8 cycles, then bresp=10. Same check for read: rresp=10 and rdata=0.
- wstrb=0x3 -> we never asserted; bresp=10.
- Concurrent write and read with rst asserted mid-W_REQ -> we, re, bvalid and rvalid all go to 0 asynchronously; after release, a fresh write completes OKAY.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite slave front end: response codes and
// the state encodings of the independent write and read FSMs.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

endpackage

// File: rtl/req_timeout.sv
// Request watchdog: counts cycles while a downstream request is held and
// flags expiry on the TIMEOUT_CYCLES-th cycle. TIMEOUT_CYCLES = 0 disables it.
module req_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic done,
    output logic expired
);

    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] LAST = LAST_INT[CNT_W-1:0];
    localparam bit ENABLED = (TIMEOUT_CYCLES != 0);

    logic [CNT_W-1:0] cnt;

    // Counter restarts on each new request and saturates at the final cycle
    // so it can never wrap if the owner lingers for a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start || done) begin
            cnt <= '0;
        end else if (active && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Expiry is raised during the last permitted request cycle; the owning
    // FSM gives a simultaneous done priority over it.
    always_comb begin
        expired = ENABLED && active && (cnt == LAST);
    end

endmodule

// File: rtl/axi_lite_slave_if.sv
// AXI4-Lite slave front end: turns the five AXI channels into a flat
// level-held request/done interface for the address decode stage.
//
// Handshake rule on every AXI channel: a transfer happens on a rising clk edge
// where valid and ready are both 1; ready never depends on valid in this
// block, and bvalid/rvalid with their payloads stay stable until accepted.
// On the decode side, we/re are held high until the matching done is sampled
// (or the watchdog expires); done outside a request is ignored.
module axi_lite_slave_if
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic [ADDR_W-1:0]   waddr,
    output logic [DATA_W-1:0]   wdata,
    output logic                we,
    input  logic                wdone,
    output logic [ADDR_W-1:0]   raddr,
    output logic                re,
    input  logic                rdone,
    input  logic [DATA_W-1:0]   rdata
);

    // ---------------------------------------------------------------- write
    wr_state_t   wr_state;
    wr_state_t   wr_next;
    logic        aw_captured;
    logic        w_captured;
    logic        w_strb_ok;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;
    logic        aw_have;
    logic        w_have;
    logic        strb_ok;
    logic        wr_start;
    logic        wr_expired;
    logic        wr_resp_load;
    logic [1:0]  wr_resp_val;

    // Ready lines are forced low while rst is high so every output reads 0.
    assign s_axi_awready = !rst && (wr_state == W_IDLE) && !aw_captured;
    assign s_axi_wready  = !rst && (wr_state == W_IDLE) && !w_captured;
    assign aw_hs         = s_axi_awvalid && s_axi_awready;
    assign w_hs          = s_axi_wvalid && s_axi_wready;
    assign b_hs          = s_axi_bvalid && s_axi_bready;
    assign aw_have       = aw_captured || aw_hs;
    assign w_have        = w_captured || w_hs;
    assign strb_ok       = w_captured ? w_strb_ok : (&s_axi_wstrb);
    assign we            = (wr_state == W_REQ);
    assign s_axi_bvalid  = (wr_state == W_RESP);

    // Write state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= W_IDLE;
        end else begin
            wr_state <= wr_next;
        end
    end

    // Write next-state: partial strobes are refused without touching decode.
    always_comb begin
        wr_next      = wr_state;
        wr_start     = 1'b0;
        wr_resp_load = 1'b0;
        wr_resp_val  = RESP_OKAY;
        case (wr_state)
            W_IDLE: begin
                if (aw_have && w_have) begin
                    if (strb_ok) begin
                        wr_next  = W_REQ;
                        wr_start = 1'b1;
                    end else begin
                        wr_next      = W_RESP;
                        wr_resp_load = 1'b1;
                        wr_resp_val  = RESP_SLVERR;
                    end
                end
            end
            W_REQ: begin
                if (wdone) begin
                    wr_next      = W_RESP;
                    wr_resp_load = 1'b1;
                    wr_resp_val  = RESP_OKAY;
                end else if (wr_expired) begin
                    wr_next      = W_RESP;
                    wr_resp_load = 1'b1;
                    wr_resp_val  = RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wr_next = W_IDLE;
                end
            end
            default: begin
                wr_next = W_IDLE;
            end
        endcase
    end

    // AW/W capture: each channel latches on its own handshake, flags clear
    // once the B response is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_captured <= 1'b0;
            w_captured  <= 1'b0;
            w_strb_ok   <= 1'b0;
            waddr       <= '0;
            wdata       <= '0;
        end else begin
            if (aw_hs) begin
                aw_captured <= 1'b1;
                waddr       <= s_axi_awaddr;
            end else if (b_hs) begin
                aw_captured <= 1'b0;
            end
            if (w_hs) begin
                w_captured <= 1'b1;
                w_strb_ok  <= &s_axi_wstrb;
                wdata      <= s_axi_wdata;
            end else if (b_hs) begin
                w_captured <= 1'b0;
            end
        end
    end

    // Write response code, held stable through W_RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axi_bresp <= RESP_OKAY;
        end else if (wr_resp_load) begin
            s_axi_bresp <= wr_resp_val;
        end
    end

    req_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wr_timeout (
        .clk    (clk),
        .rst    (rst),
        .start  (wr_start),
        .active (we),
        .done   (wdone),
        .expired(wr_expired)
    );

    // ----------------------------------------------------------------- read
    rd_state_t   rd_state;
    rd_state_t   rd_next;
    logic        ar_hs;
    logic        rd_start;
    logic        rd_expired;
    logic        rd_resp_load;
    logic [1:0]  rd_resp_val;
    logic [DATA_W-1:0] rd_data_val;

    assign s_axi_arready = !rst && (rd_state == R_IDLE);
    assign ar_hs         = s_axi_arvalid && s_axi_arready;
    assign re            = (rd_state == R_REQ);
    assign s_axi_rvalid  = (rd_state == R_RESP);

    // Read state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
        end else begin
            rd_state <= rd_next;
        end
    end

    // Read next-state: a timed-out read returns zero data with SLVERR.
    always_comb begin
        rd_next      = rd_state;
        rd_start     = 1'b0;
        rd_resp_load = 1'b0;
        rd_resp_val  = RESP_OKAY;
        rd_data_val  = '0;
        case (rd_state)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_next  = R_REQ;
                    rd_start = 1'b1;
                end
            end
            R_REQ: begin
                if (rdone) begin
                    rd_next      = R_RESP;
                    rd_resp_load = 1'b1;
                    rd_resp_val  = RESP_OKAY;
                    rd_data_val  = rdata;
                end else if (rd_expired) begin
                    rd_next      = R_RESP;
                    rd_resp_load = 1'b1;
                    rd_resp_val  = RESP_SLVERR;
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    rd_next = R_IDLE;
                end
            end
            default: begin
                rd_next = R_IDLE;
            end
        endcase
    end

    // Read address capture and R payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr       <= '0;
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                raddr <= s_axi_araddr;
            end
            if (rd_resp_load) begin
                s_axi_rdata <= rd_data_val;
                s_axi_rresp <= rd_resp_val;
            end
        end
    end

    req_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rd_timeout (
        .clk    (clk),
        .rst    (rst),
        .start  (rd_start),
        .active (re),
        .done   (rdone),
        .expired(rd_expired)
    );

endmodule

// File: tb/tb_axi_lite_slave_if.sv
// Directed + randomized bench for axi_lite_slave_if with an 8-cycle watchdog.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi_lite_slave_if;
    import axi_lite_pkg::*;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int T      = 8;
    localparam int BUDGET = 60;
    localparam int NEVER  = 1000;

    logic          clk;
    logic          rst;
    logic [AW-1:0] s_axi_awaddr;
    logic          s_axi_awvalid;
    logic          s_axi_awready;
    logic [DW-1:0] s_axi_wdata;
    logic [3:0]    s_axi_wstrb;
    logic          s_axi_wvalid;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready;
    logic [AW-1:0] s_axi_araddr;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          we;
    logic          wdone;
    logic [AW-1:0] raddr;
    logic          re;
    logic          rdone;
    logic [DW-1:0] rdata;

    int tests = 0;
    int fails = 0;

    // Scoreboard entries: {resp, data}; writes carry zero data.
    logic [33:0] exp_q[$];

    axi_lite_slave_if #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .waddr(waddr), .wdata(wdata), .we(we), .wdone(wdone),
        .raddr(raddr), .re(re), .rdone(rdone), .rdata(rdata)
    );

    // ------------------------------------------------------ clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        s_axi_awaddr  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        wdone         = 1'b0;
        rdone         = 1'b0;
        rdata         = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                                 s_axi_rvalid, we, re, s_axi_bresp, s_axi_rresp}), 64'd0);
        chk({tag, "_rdata"}, 64'(s_axi_rdata), 64'd0);
        chk({tag, "_waddr"}, 64'(waddr), 64'd0);
        chk({tag, "_wdata"}, 64'(wdata), 64'd0);
        chk({tag, "_raddr"}, 64'(raddr), 64'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
    endtask

    // ------------------------------------------------------ reference model
    // Outcome of one request from the rules: number of request cycles,
    // handshake-to-response latency, response code.
    function automatic void model(input bit strb_full, input int dly,
                                  output int n_req, output int lat, output logic [1:0] resp);
        if (!strb_full) begin
            n_req = 0; lat = 1; resp = RESP_SLVERR;
        end else if (dly < T) begin
            n_req = dly + 1; lat = dly + 2; resp = RESP_OKAY;
        end else begin
            n_req = T; lat = T + 1; resp = RESP_SLVERR;
        end
    endfunction

    // ------------------------------------------------------------- drivers
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_lag, input int w_lag,
                            input int dly, input int bhold);
        int aw_k = -1, w_k = -1, bv_k = -1, we_first = -1, we_cnt = 0;
        int n_req, lat, hs_n;
        bit b_done = 0;
        logic [1:0] resp, bresp0 = 2'b00;
        logic [33:0] e;
        model(strb == 4'hF, dly, n_req, lat, resp);
        exp_q.push_back({resp, 32'h0});
        s_axi_awaddr = addr;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        for (int k = 0; k < BUDGET && !b_done; k++) begin
            @(negedge clk);
            if (we) begin
                if (we_cnt == 0) begin
                    we_first = k;
                    chk({tag, "_waddr"}, 64'(waddr), 64'(addr));
                    chk({tag, "_wdata"}, 64'(wdata), 64'(data));
                end
                we_cnt++;
            end
            wdone = we && (we_cnt - 1 == dly);
            if (s_axi_bvalid) begin
                if (bv_k < 0) begin
                    bv_k   = k;
                    bresp0 = s_axi_bresp;
                end else begin
                    chk({tag, "_bresp_stable"}, 64'(s_axi_bresp), 64'(bresp0));
                end
                chk({tag, "_awready_in_b"}, 64'(s_axi_awready), 64'd0);
                s_axi_bready = (k - bv_k >= bhold);
                b_done = s_axi_bready;
            end else begin
                s_axi_bready = 1'b0;
            end
            s_axi_awvalid = (aw_k < 0) && (k >= aw_lag);
            s_axi_wvalid  = (w_k < 0) && (k >= w_lag);
            if (s_axi_awvalid && s_axi_awready) aw_k = k;
            if (s_axi_wvalid && s_axi_wready) w_k = k;
        end
        @(negedge clk);
        s_axi_bready = 1'b0;
        wdone = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        chk({tag, "_b_handshake"}, 64'(b_done), 64'd1);
        e = exp_q.pop_front();
        hs_n = (aw_k > w_k) ? aw_k : w_k;
        chk({tag, "_bresp"}, 64'(bresp0), 64'(e[33:32]));
        chk({tag, "_we_cycles"}, 64'(we_cnt), 64'(n_req));
        chk({tag, "_b_latency"}, 64'(bv_k - hs_n), 64'(lat));
        if (n_req > 0) chk({tag, "_we_start"}, 64'(we_first - hs_n), 64'd1);
        chk({tag, "_idle_after"}, 64'({s_axi_bvalid, s_axi_awready, s_axi_wready}), 64'b011);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input int dly, input int rhold);
        int ar_k = -1, rv_k = -1, re_first = -1, re_cnt = 0;
        int n_req, lat;
        bit r_done = 0;
        logic [1:0] resp, rresp0 = 2'b00;
        logic [31:0] rdata0 = '0;
        logic [33:0] e;
        model(1'b1, dly, n_req, lat, resp);
        exp_q.push_back({resp, (resp == RESP_OKAY) ? data : 32'h0});
        s_axi_araddr = addr;
        for (int k = 0; k < BUDGET && !r_done; k++) begin
            @(negedge clk);
            if (re) begin
                if (re_cnt == 0) begin
                    re_first = k;
                    chk({tag, "_raddr"}, 64'(raddr), 64'(addr));
                end
                re_cnt++;
            end
            rdone = re && (re_cnt - 1 == dly);
            rdata = rdone ? data : $urandom;
            if (s_axi_rvalid) begin
                if (rv_k < 0) begin
                    rv_k   = k;
                    rresp0 = s_axi_rresp;
                    rdata0 = s_axi_rdata;
                end else begin
                    chk({tag, "_r_stable"}, 64'({s_axi_rresp, s_axi_rdata}), 64'({rresp0, rdata0}));
                end
                s_axi_rready = (k - rv_k >= rhold);
                r_done = s_axi_rready;
            end else begin
                s_axi_rready = 1'b0;
            end
            s_axi_arvalid = (ar_k < 0);
            if (s_axi_arvalid && s_axi_arready) ar_k = k;
        end
        @(negedge clk);
        s_axi_rready = 1'b0;
        rdone = 1'b0;
        s_axi_arvalid = 1'b0;
        chk({tag, "_r_handshake"}, 64'(r_done), 64'd1);
        e = exp_q.pop_front();
        chk({tag, "_rresp"}, 64'(rresp0), 64'(e[33:32]));
        chk({tag, "_rdata"}, 64'(rdata0), 64'(e[31:0]));
        chk({tag, "_re_cycles"}, 64'(re_cnt), 64'(n_req));
        chk({tag, "_r_latency"}, 64'(rv_k - ar_k), 64'(lat));
        chk({tag, "_re_start"}, 64'(re_first - ar_k), 64'd1);
        chk({tag, "_idle_after"}, 64'({s_axi_rvalid, s_axi_arready}), 64'b01);
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        apply_reset();

        do_write("w_same_cycle", 32'h0000_0010, 32'hA5A5_5A5A, 4'hF, 0, 0, 0, 0);
        do_write("w_before_aw", 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 3, 0, 1, 4);
        do_write("aw_before_w", 32'h0000_0033, 32'h0BAD_F00D, 4'hF, 0, 2, 2, 1);
        do_read("r_basic", 32'h0000_0004, 32'h1234_5678, 3, 0);
        do_write("w_timeout", 32'h0000_0040, 32'h1111_2222, 4'hF, 0, 0, NEVER, 0);
        do_read("r_timeout", 32'h0000_0044, 32'h3333_4444, NEVER, 2);
        do_write("w_strb3", 32'h0000_0048, 32'h5555_6666, 4'h3, 0, 0, 0, 0);
        do_write("w_done_at_expiry", 32'h0000_004C, 32'h7777_8888, 4'hF, 1, 0, T - 1, 0);
        do_read("r_done_at_expiry", 32'h0000_0050, 32'h9999_AAAA, T - 1, 0);

        // Done strobes while idle must not start anything.
        wdone = 1'b1;
        rdone = 1'b1;
        repeat (3) @(negedge clk);
        chk("stray_done", 64'({we, re, s_axi_bvalid, s_axi_rvalid}), 64'd0);
        wdone = 1'b0;
        rdone = 1'b0;

        for (int i = 0; i < 10; i++) begin
            logic [3:0] strb;
            strb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            do_write("w_rand", $urandom, $urandom, strb, $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, T + 1), $urandom_range(0, 3));
            do_read("r_rand", $urandom, $urandom, $urandom_range(0, T + 1), $urandom_range(0, 3));
        end

        // Concurrent write and read, reset while both requests are held.
        @(negedge clk);
        s_axi_awaddr  = 32'h0000_0100;
        s_axi_wdata   = 32'hCAFE_0001;
        s_axi_wstrb   = 4'hF;
        s_axi_araddr  = 32'h0000_0104;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        chk("conc_we_re", 64'({we, re}), 64'b11);
        #2 rst = 1'b1;
        #1 chk("async_rst", 64'({we, re, s_axi_bvalid, s_axi_rvalid}), 64'd0);
        @(negedge clk);
        check_all_zero("mid_rst");
        rst = 1'b0;
        do_write("w_after_rst", 32'h0000_0200, 32'h0F0F_F0F0, 4'hF, 0, 0, 0, 0);
        do_read("r_after_rst", 32'h0000_0204, 32'hF0F0_0F0F, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
